// File: rtl/seven_seg_scan_ctrl_pkg.sv
// rtl/seven_seg_scan_ctrl_pkg.sv - shared segment patterns and scan FSM state type
//
// Purpose:
//   Common constants for the seven-segment scan controller and its decoder.
//   Segment patterns are active-low, laid out as {dp, g, f, e, d, c, b, a};
//   the dp bit is 1 (off) in every pattern so callers can overlay their own dp.
//
// Contents:
//   SEG_0..SEG_9  decoded digit patterns
//   SEG_BLANK     all segments and dp off
//   SEG7_OFF      seven segments off, dp excluded
//   scan_state_e  BLANK guard interval / DRIVE interval of a digit slot

package seven_seg_scan_ctrl_pkg;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [6:0] SEG7_OFF  = 7'h7F;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_e;

endpackage

// File: rtl/bcd_to_seg.sv
// rtl/bcd_to_seg.sv - BCD nibble to active-low seven-segment pattern
//
// Purpose:
//   Pure combinational decode of one BCD digit. Codes 10..15 are not
//   displayable and turn every segment off.
//
// Ports:
//   bcd  in   4  BCD digit value
//   seg  out  7  active-low segments, bit 6 = g ... bit 0 = a

module bcd_to_seg
  import seven_seg_scan_ctrl_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK[6:0];
    case (bcd)
      4'd0:    seg = SEG_0[6:0];
      4'd1:    seg = SEG_1[6:0];
      4'd2:    seg = SEG_2[6:0];
      4'd3:    seg = SEG_3[6:0];
      4'd4:    seg = SEG_4[6:0];
      4'd5:    seg = SEG_5[6:0];
      4'd6:    seg = SEG_6[6:0];
      4'd7:    seg = SEG_7[6:0];
      4'd8:    seg = SEG_8[6:0];
      4'd9:    seg = SEG_9[6:0];
      default: seg = SEG_BLANK[6:0];
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// rtl/seven_seg_scan_ctrl.sv - multiplexed seven-segment display scan controller
//
// Purpose:
//   Time-multiplexes NUM_DIGITS BCD digits onto one shared segment bus.
//   Every digit slot is REFRESH_DIV clocks long: BLANK_CYCLES of all-off
//   guard (kills ghosting while anodes switch) followed by the driven part.
//   New digit values are double-buffered and only become visible at a frame
//   boundary, so a frame never shows a mix of old and new digits.
//
// Parameters:
//   NUM_DIGITS    number of digits, 2..8
//   REFRESH_DIV   clocks per digit slot
//   BLANK_CYCLES  guard clocks at slot start, 1..REFRESH_DIV-1
//
// Ports:
//   clk          in   1             system clock, rising edge
//   rst          in   1             synchronous active-high reset
//   digits_in    in   4*NUM_DIGITS  BCD digits, nibble i = digit i (0 = LSD)
//   dp_in        in   NUM_DIGITS    decimal point request per digit
//   load         in   1             strobe capturing digits_in/dp_in
//   lz_blank_en  in   1             leading-zero blanking enable
//   seg_out      out  8             active-low segments {dp, g..a}, registered
//   an_out       out  NUM_DIGITS    active-low digit enables, registered
//   slot_idx     out  clog2(N)      digit slot currently scanned
//   frame_done   out  1             one-cycle pulse on the last clock of a frame

module seven_seg_scan_ctrl
  import seven_seg_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [4*NUM_DIGITS-1:0]       digits_in,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  input  logic                          load,
  input  logic                          lz_blank_en,
  output logic [7:0]                    seg_out,
  output logic [NUM_DIGITS-1:0]         an_out,
  output logic [$clog2(NUM_DIGITS)-1:0] slot_idx,
  output logic                          frame_done
);

  localparam int SLOT_W = $clog2(NUM_DIGITS);
  localparam int CNT_W  = $clog2(REFRESH_DIV);

  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0]  BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(NUM_DIGITS - 1);

  // ---------------------------------------------------------------------------
  // Scan FSM: state register
  // ---------------------------------------------------------------------------
  scan_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic              frame_tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_BLANK;
      cnt_q   <= '0;
      slot_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Scan FSM: next state. The counter spans the whole slot; BLANK covers
  // counts 0..BLANK_CYCLES-1 and DRIVE the remainder.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    slot_d     = slot_q;
    frame_tick = 1'b0;
    case (state_q)
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          if (slot_q == SLOT_LAST) begin
            slot_d     = '0;
            frame_tick = 1'b1;
          end else begin
            slot_d = slot_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_BLANK;
        cnt_d   = '0;
      end
    endcase
  end

  // Gated by rst so a reset landing on the boundary clock never reports a frame.
  assign frame_done = frame_tick & ~rst;
  assign slot_idx   = slot_q;

  // ---------------------------------------------------------------------------
  // Double-buffered display registers. A load on the boundary clock bypasses
  // pending so it shows in the frame that is just starting.
  // ---------------------------------------------------------------------------
  logic [4*NUM_DIGITS-1:0] pend_digits, act_digits;
  logic [NUM_DIGITS-1:0]   pend_dp, act_dp;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_digits <= '0;
      pend_dp     <= '0;
      act_digits  <= '0;
      act_dp      <= '0;
    end else begin
      if (load) begin
        pend_digits <= digits_in;
        pend_dp     <= dp_in;
      end
      if (frame_tick) begin
        act_digits <= load ? digits_in : pend_digits;
        act_dp     <= load ? dp_in     : pend_dp;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Leading-zero detect: lz_zero[i] is set when digit i and every digit above
  // it are zero.
  // ---------------------------------------------------------------------------
  logic [NUM_DIGITS-1:0] lz_zero;
  logic                  zero_run;

  always_comb begin
    lz_zero  = '0;
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run   = zero_run && (act_digits[4*i +: 4] == 4'd0);
      lz_zero[i] = zero_run;
    end
  end

  // ---------------------------------------------------------------------------
  // Active-slot mux feeding the single shared decoder.
  // ---------------------------------------------------------------------------
  logic [3:0] cur_digit;
  logic       cur_dp;
  logic       cur_lz;
  logic [6:0] cur_seg7;

  always_comb begin
    cur_digit = '0;
    cur_dp    = 1'b0;
    cur_lz    = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (slot_q == SLOT_W'(i)) begin
        cur_digit = act_digits[4*i +: 4];
        cur_dp    = act_dp[i];
        cur_lz    = lz_zero[i];
      end
    end
  end

  bcd_to_seg u_bcd_to_seg (
    .bcd (cur_digit),
    .seg (cur_seg7)
  );

  // ---------------------------------------------------------------------------
  // Output pattern for the current state, registered below so pins change one
  // clock after the state that selects them. Digit 0 is never zero-blanked;
  // the dp overlay survives blanking.
  // ---------------------------------------------------------------------------
  logic [7:0]            seg_d;
  logic [NUM_DIGITS-1:0] an_d;
  logic                  lz_hit;

  always_comb begin
    an_d   = '1;
    seg_d  = SEG_BLANK;
    lz_hit = lz_blank_en && (slot_q != '0) && cur_lz;
    if (state_q == ST_DRIVE) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        an_d[i] = (slot_q != SLOT_W'(i));
      end
      seg_d = {~cur_dp, lz_hit ? SEG7_OFF : cur_seg7};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_out <= SEG_BLANK;
      an_out  <= '1;
    end else begin
      seg_out <= seg_d;
      an_out  <= an_d;
    end
  end

endmodule
